// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with a TXDATA write buffer and a STATUS register.
// Define UART_TX_FIFO_EN to use a 4-entry FIFO instead of a single holding register.
module uart_tx_io #(
  parameter int unsigned BAUD_DIV = 200
) (
  input  logic        uartclk,
  input  logic        uartrst,
  input  logic        uartcs,
  input  logic        uartwrite,
  input  logic        uartread,
  input  logic [1:0]  uartaddr,
  input  logic [7:0]  uartwdata,
  output logic [15:0] uartrdata,
  output logic        tx,
  output logic        busy
);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned Depth = 4;
`else
  localparam int unsigned Depth = 1;
`endif
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned MemN = 1 << PtrW;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [15:0]     BaudMax = 16'(BAUD_DIV - 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [7:0]      mem [MemN];

  logic wr_txdata, status_rd, full, empty, push, pop;

  assign wr_txdata = uartcs & uartwrite & (uartaddr == 2'b00);
  assign status_rd = uartcs & uartread & (uartaddr == 2'b10);
  assign full      = (count_q == CntFull);
  assign empty     = (count_q == '0);
  // Fullness is judged before the same-cycle pop, so a write racing a pop is still dropped.
  assign push      = wr_txdata & ~full;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge uartclk) begin
    if (push) mem[wr_ptr_q] <= uartwdata;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr_q];
          baud_d  = BaudMax;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_q == '0) begin
          baud_d  = BaudMax;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StData: begin
        if (baud_q == '0) begin
          baud_d  = BaudMax;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StStop: begin
        if (baud_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = mem[rd_ptr_q];
            baud_d  = BaudMax;
            state_d = StStart;
          end else begin
            baud_d  = '0;
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Line and busy are registered from the current state, so both lag the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shreg_q[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != StIdle) || !empty;
    if (wr_txdata && full) begin
      ovf_d = 1'b1;
    end else if (status_rd) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge uartclk or posedge uartrst) begin
    if (uartrst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign uartrdata = (status_rd && !uartrst) ? {13'b0, ovf_q, full, busy_q} : 16'h0000;
  assign tx        = tx_q;
  assign busy      = busy_q;

endmodule
